// File: rtl/fifo_pkg.sv
// Shared types and helpers for the programmable synchronous FIFO.
//   fifo_status_t : bundle of the FIFO's level and sticky status flags
//   count_width() : width of a word counter able to hold 0..depth inclusive
package fifo_pkg;

    typedef struct packed {
        logic full;
        logic almost_full;
        logic empty;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    // One extra bit so that a completely full FIFO (count == depth) is representable.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Two-port storage array for the FIFO: one synchronous write port and one
// asynchronous (combinational) read port.
//   clk      : write clock, rising edge
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_addr  : read address
//   rd_data  : read data, combinational from rd_addr
module fifo_mem_2p #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; its contents only matter once written, and the
    // FIFO pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_sync_prog.sv
// Parametrised synchronous FIFO with selectable first-word-fall-through (FWFT)
// or registered-read output, programmable almost thresholds, synchronous flush,
// sticky overflow/underflow flags and a high-water mark.
//   clk, rst              : clock (rising edge), asynchronous active-high reset
//   flush                 : synchronous empty request, overrides wr_en/rd_en
//   clr_status            : clears overflow, underflow and max_count
//   wr_en, wr_data        : push request and data; full/almost_full report level
//   rd_en, rd_data        : pop request (FWFT: acknowledge) and read data
//   rd_valid              : FWFT: rd_data holds head; registered: 1-cycle pulse
//   empty, almost_empty   : no word available for a pop / count <= ae_thresh
//   af_thresh, ae_thresh  : quasi-static almost-full / almost-empty thresholds
//   count, max_count      : words held (incl. FWFT output register), high-water mark
//   overflow, underflow   : sticky error flags
module fifo_sync_prog
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 64,
    parameter int FWFT        = 1,
    parameter int ADDR_WIDTH  = $clog2(FIFO_DEPTH),
    parameter int COUNT_WIDTH = count_width(FIFO_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   clr_status,
    input  logic                   wr_en,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    output logic                   full,
    output logic                   almost_full,
    input  logic                   rd_en,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   rd_valid,
    output logic                   empty,
    output logic                   almost_empty,
    input  logic [COUNT_WIDTH-1:0] af_thresh,
    input  logic [COUNT_WIDTH-1:0] ae_thresh,
    output logic [COUNT_WIDTH-1:0] count,
    output logic [COUNT_WIDTH-1:0] max_count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam bit                     IS_FWFT = (FWFT != 0);
    localparam logic [COUNT_WIDTH-1:0] DEPTH_C = COUNT_WIDTH'(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0]  wr_ptr;
    logic [ADDR_WIDTH-1:0]  rd_ptr;
    logic [DATA_WIDTH-1:0]  mem_rdata;
    logic [COUNT_WIDTH-1:0] count_next;
    logic                   overflow_q;
    logic                   underflow_q;
    logic                   push;
    logic                   pop;
    logic                   load;
    logic                   ovf_evt;
    logic                   udf_evt;
    logic                   mem_has_data;
    fifo_status_t           status;

    fifo_mem_2p #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_addr (rd_ptr),
        .rd_data (mem_rdata)
    );

    // NOTE: every field gets a default first so this block can never infer a latch.
    always_comb begin
        status              = '0;
        status.full         = (count == DEPTH_C);
        status.almost_full  = (count >= af_thresh);
        status.almost_empty = (count <= ae_thresh);
        // In FWFT mode a word just written sits in memory for one cycle before it
        // reaches the output register, so availability follows rd_valid, not count.
        status.empty        = IS_FWFT ? !rd_valid : (count == '0);
        status.overflow     = overflow_q;
        status.underflow    = underflow_q;
    end

    assign full         = status.full;
    assign almost_full  = status.almost_full;
    assign empty        = status.empty;
    assign almost_empty = status.almost_empty;
    assign overflow     = status.overflow;
    assign underflow    = status.underflow;

    // Requests are qualified by the pre-edge flags; flush swallows them silently.
    assign push    = wr_en & !status.full  & !flush;
    assign pop     = rd_en & !status.empty & !flush;
    assign ovf_evt = wr_en &  status.full  & !flush;
    assign udf_evt = rd_en &  status.empty & !flush;

    // FWFT: count includes the output register, so memory holds count - rd_valid words.
    assign mem_has_data = IS_FWFT ? (count != COUNT_WIDTH'(rd_valid)) : (count != '0);

    // A memory read advances rd_ptr: in FWFT whenever the output register is free or
    // being consumed and memory has a word; in registered mode on every pop.
    assign load = IS_FWFT ? ((!rd_valid | pop) & mem_has_data & !flush) : pop;

    assign count_next = flush ? '0 : (count + COUNT_WIDTH'(push) - COUNT_WIDTH'(pop));

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            max_count   <= '0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count <= count_next;
            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                rd_valid <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
                end
                if (load) begin
                    rd_ptr  <= rd_ptr + ADDR_WIDTH'(1);
                    rd_data <= mem_rdata;
                end
                rd_valid <= IS_FWFT ? (load | (rd_valid & !pop)) : pop;
            end
            // A same-cycle event beats clr_status so it is never lost.
            overflow_q  <= (overflow_q  & !clr_status) | ovf_evt;
            underflow_q <= (underflow_q & !clr_status) | udf_evt;
            if (clr_status || (count_next > max_count)) begin
                max_count <= count_next;
            end
        end
    end

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Self-checking bench for fifo_sync_prog. Drives one FWFT and one registered-read
// instance with the same stimulus and compares both against queue-based models.
module tb_fifo_sync_prog;

    localparam int DW    = 8;
    localparam int DEPTH = 64;
    localparam int CW    = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush, clr_status, wr_en, rd_en;
    logic [DW-1:0] wr_data;
    logic [CW-1:0] af_thresh, ae_thresh;

    logic          f_full, f_af, f_empty, f_ae, f_rd_valid, f_ovf, f_udf;
    logic [DW-1:0] f_rd_data;
    logic [CW-1:0] f_count, f_max;
    logic          n_full, n_af, n_empty, n_ae, n_rd_valid, n_ovf, n_udf;
    logic [DW-1:0] n_rd_data;
    logic [CW-1:0] n_count, n_max;

    always #5 clk = ~clk;

    fifo_sync_prog #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .flush(flush), .clr_status(clr_status),
        .wr_en(wr_en), .wr_data(wr_data), .full(f_full), .almost_full(f_af),
        .rd_en(rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid), .empty(f_empty),
        .almost_empty(f_ae), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
        .count(f_count), .max_count(f_max), .overflow(f_ovf), .underflow(f_udf)
    );

    fifo_sync_prog #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(0)) u_reg (
        .clk(clk), .rst(rst), .flush(flush), .clr_status(clr_status),
        .wr_en(wr_en), .wr_data(wr_data), .full(n_full), .almost_full(n_af),
        .rd_en(rd_en), .rd_data(n_rd_data), .rd_valid(n_rd_valid), .empty(n_empty),
        .almost_empty(n_ae), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
        .count(n_count), .max_count(n_max), .overflow(n_ovf), .underflow(n_udf)
    );

    // Reference models: a queue of held words per instance plus flag state.
    logic [DW-1:0] qf[$];
    logic [DW-1:0] qn[$];
    bit            rvf, rvn, ovff, ovfn, udff, udfn;
    int            maxf, maxn;
    logic [DW-1:0] rdn;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [CW-1:0] af;
        logic [CW-1:0] ae;
        logic          exp_af;
        logic          exp_ae;
    } thr_vec_t;

    thr_vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        qf.delete();
        qn.delete();
        rvf = 0; rvn = 0; ovff = 0; ovfn = 0; udff = 0; udfn = 0;
        maxf = 0; maxn = 0; rdn = '0;
    endtask

    // Advance both models by one clock edge using the current inputs.
    task automatic model_edge();
        bit full_x, empty_x, ovf, udf, pop;
        int keep;
        // FWFT: the head is visible once a word has been held across an edge.
        full_x  = (qf.size() == DEPTH);
        empty_x = !rvf;
        ovf = !flush && wr_en && full_x;
        udf = !flush && rd_en && empty_x;
        if (flush) begin
            qf.delete();
            rvf = 0;
        end else begin
            pop  = rd_en && !empty_x;
            keep = qf.size() - (pop ? 1 : 0);
            if (pop) void'(qf.pop_front());
            if (wr_en && !full_x) qf.push_back(wr_data);
            rvf = (keep > 0);
        end
        ovff = (ovff && !clr_status) || ovf;
        udff = (udff && !clr_status) || udf;
        maxf = clr_status ? qf.size() : ((qf.size() > maxf) ? qf.size() : maxf);
        // Registered read: a pop presents the head word for one cycle.
        full_x  = (qn.size() == DEPTH);
        empty_x = (qn.size() == 0);
        ovf = !flush && wr_en && full_x;
        udf = !flush && rd_en && empty_x;
        rvn = 0;
        if (flush) begin
            qn.delete();
        end else begin
            if (rd_en && !empty_x) begin
                rdn = qn.pop_front();
                rvn = 1;
            end
            if (wr_en && !full_x) qn.push_back(wr_data);
        end
        ovfn = (ovfn && !clr_status) || ovf;
        udfn = (udfn && !clr_status) || udf;
        maxn = clr_status ? qn.size() : ((qn.size() > maxn) ? qn.size() : maxn);
    endtask

    task automatic compare_all();
        check("f.count", f_count, qf.size());
        check("f.empty", f_empty, !rvf);
        check("f.full", f_full, qf.size() == DEPTH);
        check("f.almost_full", f_af, qf.size() >= af_thresh);
        check("f.almost_empty", f_ae, qf.size() <= ae_thresh);
        check("f.rd_valid", f_rd_valid, rvf);
        if (rvf) check("f.rd_data", f_rd_data, qf[0]);
        check("f.overflow", f_ovf, ovff);
        check("f.underflow", f_udf, udff);
        check("f.max_count", f_max, maxf);
        check("n.count", n_count, qn.size());
        check("n.empty", n_empty, qn.size() == 0);
        check("n.full", n_full, qn.size() == DEPTH);
        check("n.almost_full", n_af, qn.size() >= af_thresh);
        check("n.almost_empty", n_ae, qn.size() <= ae_thresh);
        check("n.rd_valid", n_rd_valid, rvn);
        check("n.rd_data", n_rd_data, rdn);
        check("n.overflow", n_ovf, ovfn);
        check("n.underflow", n_udf, udfn);
        check("n.max_count", n_max, maxn);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Reset values with af_thresh=60, ae_thresh=4.
    task automatic check_reset_values(input string tag);
        check({tag, " f.count"}, f_count, 0);
        check({tag, " f.empty"}, f_empty, 1);
        check({tag, " f.full"}, f_full, 0);
        check({tag, " f.almost_empty"}, f_ae, 1);
        check({tag, " f.almost_full"}, f_af, 0);
        check({tag, " f.rd_valid"}, f_rd_valid, 0);
        check({tag, " f.rd_data"}, f_rd_data, 0);
        check({tag, " f.flags"}, {f_ovf, f_udf}, 0);
        check({tag, " f.max_count"}, f_max, 0);
        check({tag, " n.count"}, n_count, 0);
        check({tag, " n.empty"}, n_empty, 1);
        check({tag, " n.rd_data"}, n_rd_data, 0);
        check({tag, " n.flags"}, {n_ovf, n_udf, n_rd_valid}, 0);
        check({tag, " n.max_count"}, n_max, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{af: 7'd10,  ae: 7'd0,   exp_af: 1'b1, exp_ae: 1'b0};
        vecs[1] = '{af: 7'd11,  ae: 7'd10,  exp_af: 1'b0, exp_ae: 1'b1};
        vecs[2] = '{af: 7'd0,   ae: 7'd9,   exp_af: 1'b1, exp_ae: 1'b0};
        vecs[3] = '{af: 7'd64,  ae: 7'd64,  exp_af: 1'b0, exp_ae: 1'b1};
        vecs[4] = '{af: 7'd9,   ae: 7'd11,  exp_af: 1'b1, exp_ae: 1'b1};
        vecs[5] = '{af: 7'd127, ae: 7'd127, exp_af: 1'b0, exp_ae: 1'b1};

        rst = 1'b0; flush = 0; clr_status = 0; wr_en = 0; rd_en = 0; wr_data = '0;
        af_thresh = 7'd60; ae_thresh = 7'd4;
        #1 rst = 1'b1;
        #11;
        check_reset_values("reset");
        rst = 1'b0;
        model_reset();

        // 1: fill to full
        wr_en = 1;
        for (int i = 0; i < DEPTH; i++) begin
            wr_data = DW'(i);
            step();
        end
        wr_en = 0;
        check("t1 f.full", f_full, 1);
        check("t1 f.count", f_count, 64);
        check("t1 f.max_count", f_max, 64);
        check("t1 f.almost_full", f_af, 1);
        check("t1 n.full", n_full, 1);

        // 2: overflow, then drain in order
        wr_en = 1; wr_data = 8'hAA;
        step();
        wr_en = 0;
        check("t2 f.overflow", f_ovf, 1);
        check("t2 f.count", f_count, 64);
        check("t2 n.overflow", n_ovf, 1);
        rd_en = 1;
        for (int i = 0; i < DEPTH; i++) begin
            check("t2 f.head", f_rd_data, i);
            step();
            check("t2 n.data", n_rd_data, i);
        end
        rd_en = 0;
        check("t2 f.empty", f_empty, 1);
        check("t2 n.empty", n_empty, 1);

        // 3: FWFT fall-through latency
        wr_en = 1; wr_data = 8'h5A;
        step();
        wr_en = 0;
        check("t3 f.rd_valid N", f_rd_valid, 0);
        step();
        check("t3 f.rd_valid N+1", f_rd_valid, 1);
        check("t3 f.rd_data", f_rd_data, 8'h5A);
        check("t3 n.empty", n_empty, 0);
        rd_en = 1;
        step();
        rd_en = 0;
        check("t3 f.empty", f_empty, 1);
        check("t3 n.rd_valid", n_rd_valid, 1);
        check("t3 n.rd_data", n_rd_data, 8'h5A);
        step();
        check("t3 n.rd_valid pulse", n_rd_valid, 0);

        // 4: threshold table at count=10, then streaming and underflow
        wr_en = 1;
        for (int i = 0; i < 10; i++) begin
            wr_data = DW'(8'h10 + i);
            step();
        end
        wr_en = 0;
        step();
        foreach (vecs[i]) begin
            af_thresh = vecs[i].af;
            ae_thresh = vecs[i].ae;
            #1;
            check($sformatf("t4 vec%0d f.almost_full", i), f_af, vecs[i].exp_af);
            check($sformatf("t4 vec%0d f.almost_empty", i), f_ae, vecs[i].exp_ae);
            check($sformatf("t4 vec%0d n.almost_full", i), n_af, vecs[i].exp_af);
        end
        af_thresh = 7'd60; ae_thresh = 7'd4;
        wr_en = 1; rd_en = 1;
        for (int i = 0; i < 200; i++) begin
            wr_data = DW'($urandom);
            step();
        end
        wr_en = 0;
        check("t4 f.count", f_count, 10);
        check("t4 n.count", n_count, 10);
        for (int i = 0; i < 11; i++) step();
        rd_en = 0;
        check("t4 f.underflow", f_udf, 1);
        check("t4 n.underflow", n_udf, 1);

        // 5: flush and clr_status interactions
        wr_en = 1;
        for (int i = 0; i < 20; i++) begin
            wr_data = DW'(i);
            step();
        end
        flush = 1;
        step();
        flush = 0; wr_en = 0;
        check("t5 f.count", f_count, 0);
        check("t5 f.empty", f_empty, 1);
        check("t5 f.overflow kept", f_ovf, 1);
        check("t5 f.max kept", f_max, 64);
        clr_status = 1;
        step();
        clr_status = 0;
        check("t5 f.max_count", f_max, 0);
        check("t5 f.overflow clr", f_ovf, 0);
        check("t5 n.underflow clr", n_udf, 0);
        flush = 1; rd_en = 1;
        step();
        flush = 0;
        check("t5 flush drops read", f_udf, 0);
        clr_status = 1;
        step();
        rd_en = 0;
        check("t5 f.underflow wins", f_udf, 1);
        check("t5 n.underflow wins", n_udf, 1);
        wr_en = 1; wr_data = 8'h33;
        step();
        clr_status = 0; wr_en = 0;
        check("t5 f.max reload", f_max, 1);
        check("t5 f.underflow clr", f_udf, 0);

        // Random traffic in blocks with varying bias and thresholds
        for (int blk = 0; blk < 12; blk++) begin
            int wp, rp;
            wp = $urandom_range(20, 90);
            rp = $urandom_range(20, 90);
            af_thresh = CW'($urandom_range(0, 64));
            ae_thresh = CW'($urandom_range(0, 64));
            for (int i = 0; i < 150; i++) begin
                wr_en      = ($urandom_range(0, 99) < wp);
                rd_en      = ($urandom_range(0, 99) < rp);
                wr_data    = DW'($urandom);
                flush      = ($urandom_range(0, 99) == 0);
                clr_status = ($urandom_range(0, 79) == 0);
                step();
            end
        end
        flush = 0; clr_status = 0; rd_en = 0;
        af_thresh = 7'd60; ae_thresh = 7'd4;

        // 6: asynchronous reset in the middle of a write burst
        wr_en = 1;
        for (int i = 0; i < 5; i++) begin
            wr_data = DW'(8'hC0 + i);
            step();
        end
        #2 rst = 1'b1;
        #1;
        check_reset_values("t6");
        model_reset();
        wr_en = 0;
        #2 rst = 1'b0;
        wr_en = 1;
        for (int i = 0; i < 3; i++) begin
            wr_data = DW'(8'hE0 + i);
            step();
        end
        wr_en = 0; rd_en = 1;
        for (int i = 0; i < 4; i++) step();
        rd_en = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
